// File: rtl/masked_and_seq_pkg.sv
// Shared types and constants for the bit-serial masked AND sequencer.
package masked_and_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bit-index counter width; a 1-bit word still needs a 1-bit index.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/masked_and_seq_dom_and_cell.sv
// Combinational 1-bit first-order domain-oriented masked AND cell.
module dom_and_cell (
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic z,
  output logic c0,
  output logic c1
);

  // Cross-domain terms are refreshed with z before joining the inner-domain term.
  assign c0 = (a0 & b0) ^ ((a0 & b1) ^ z);
  assign c1 = (a1 & b1) ^ ((a1 & b0) ^ z);

endmodule

// File: rtl/masked_and_seq.sv
// Bit-serial masked AND sequencer: one fresh random bit per result bit, one DOM cell.
// Optional build macro MASKED_AND_SEQ_PRECHARGE_EN zeroes cell inputs outside EVAL.
module masked_and_seq
  import masked_and_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic             rnd_req,
  input  logic             rnd_ack,
  input  logic             rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c0,
  output logic [WIDTH-1:0] c1,
  output logic             busy,
  output state_e           state_o
);

  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid is never withdrawn before the transfer and data is stable while valid.

  state_e           state_q;
  logic [WIDTH-1:0] a0_q, a1_q, b0_q, b1_q;
  logic [WIDTH-1:0] c0_q, c1_q;
  logic [WIDTH-1:0] c0_d, c1_d;
  logic [IW-1:0]    idx_q;
  logic             z_q;
  logic             in_ready_q;

  logic cell_a0, cell_a1, cell_b0, cell_b1, cell_z;
  logic cell_c0, cell_c1;

`ifdef MASKED_AND_SEQ_PRECHARGE_EN
  logic cell_en;
  assign cell_en = (state_q == EVAL);
  assign cell_a0 = cell_en & a0_q[idx_q];
  assign cell_a1 = cell_en & a1_q[idx_q];
  assign cell_b0 = cell_en & b0_q[idx_q];
  assign cell_b1 = cell_en & b1_q[idx_q];
  assign cell_z  = cell_en & z_q;
`else
  assign cell_a0 = a0_q[idx_q];
  assign cell_a1 = a1_q[idx_q];
  assign cell_b0 = b0_q[idx_q];
  assign cell_b1 = b1_q[idx_q];
  assign cell_z  = z_q;
`endif

  dom_and_cell u_cell (
    .a0 (cell_a0),
    .a1 (cell_a1),
    .b0 (cell_b0),
    .b1 (cell_b1),
    .z  (cell_z),
    .c0 (cell_c0),
    .c1 (cell_c1)
  );

  always_comb begin
    c0_d        = c0_q;
    c1_d        = c1_q;
    c0_d[idx_q] = cell_c0;
    c1_d[idx_q] = cell_c1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a0_q       <= '0;
      a1_q       <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      c0_q       <= '0;
      c1_q       <= '0;
      idx_q      <= '0;
      z_q        <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a0_q       <= a0;
            a1_q       <= a1;
            b0_q       <= b0;
            b1_q       <= b1;
            c0_q       <= '0;
            c1_q       <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= FETCH;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        FETCH: begin
          if (rnd_ack) begin
            z_q     <= rnd;
            state_q <= EVAL;
          end
        end
        EVAL: begin
          c0_q <= c0_d;
          c1_q <= c1_d;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + IW'(1);
            state_q <= FETCH;
          end
        end
        DONE: begin
          // Zeroize the result and the spent random bit on hand-off.
          if (out_ready) begin
            c0_q       <= '0;
            c1_q       <= '0;
            z_q        <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign rnd_req   = (state_q == FETCH);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign c0        = c0_q;
  assign c1        = c1_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_masked_and_seq.sv
// Self-checking bench for masked_and_seq: scoreboard of expected result shares.
module tb_masked_and_seq;
  import masked_and_seq_pkg::*;

  localparam int W     = 8;
  localparam int STALL = 5;
`ifdef MASKED_AND_SEQ_PRECHARGE_EN
  localparam int N_RAND = 1000;
`else
  localparam int N_RAND = 40;
`endif

  logic         clk, rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a0, a1, b0, b1;
  logic         rnd_req, rnd_ack, rnd;
  logic         out_valid, out_ready;
  logic [W-1:0] c0, c1;
  logic         busy;
  state_e       state_o;

  masked_and_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a0        (a0),
    .a1        (a1),
    .b0        (b0),
    .b1        (b1),
    .rnd_req   (rnd_req),
    .rnd_ack   (rnd_ack),
    .rnd       (rnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c0        (c0),
    .c1        (c1),
    .busy      (busy),
    .state_o   (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] exp_q[$];

  // randomness source state
  logic [W-1:0] z_vec    = '0;
  int           bit_cnt  = 0;
  int           stall_bit = -1;
  logic         noise_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // randomness responder: acks each request with the next bit of z_vec
  initial begin
    rnd_ack = 1'b0;
    rnd     = 1'b0;
    forever begin
      @(negedge clk);
      if (rnd_req && bit_cnt == stall_bit) begin
        rnd_ack   = 1'b0;
        stall_bit = -1;
        repeat (STALL) begin
          @(negedge clk);
          check_val("req_held", 32'(rnd_req), 32'd1);
        end
      end
      if (rnd_req) begin
        rnd_ack = 1'b1;
        rnd     = (bit_cnt < W) ? z_vec[bit_cnt] : 1'b0;
        bit_cnt++;
      end else begin
        rnd_ack = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        rnd     = 1'($urandom_range(0, 1));
      end
    end
  end

`ifdef MASKED_AND_SEQ_PRECHARGE_EN
  initial begin
    forever begin
      @(negedge clk);
      if (rnd_req)
        check_val("precharge",
                  32'({dut.cell_a0, dut.cell_a1, dut.cell_b0, dut.cell_b1, dut.cell_z}), 32'd0);
    end
  end
`endif

  // driver: one full operation including output hand-off
  task automatic run_op(input logic [W-1:0] ta0, input logic [W-1:0] ta1,
                        input logic [W-1:0] tb0, input logic [W-1:0] tb1,
                        input logic [W-1:0] tz, input int tstall, input int hold,
                        output logic [W-1:0] got_c0);
    logic [W-1:0] bb, e0, e1;
    logic [2*W-1:0] exp;
    logic [W-1:0] h0, h1;
    int cnt;
    int wait_cnt;
    bb = tb0 ^ tb1;
    e0 = (ta0 & bb) ^ tz;
    e1 = (ta1 & bb) ^ tz;
    exp_q.push_back({e1, e0});
    z_vec     = tz;
    bit_cnt   = 0;
    stall_bit = tstall;
    wait_cnt  = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check_val("in_ready_wait", 32'(in_ready), 32'd1);
    a0 = ta0; a1 = ta1; b0 = tb0; b1 = tb1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!out_valid && cnt < 300);
    check_val("latency", 32'(cnt), 32'(2 * W + ((tstall >= 0) ? STALL : 0)));
    exp = exp_q.pop_front();
    check_val("c0", 32'(c0), 32'(exp[W-1:0]));
    check_val("c1", 32'(c1), 32'(exp[2*W-1:W]));
    check_val("unmasked", 32'(c0 ^ c1), 32'((ta0 ^ ta1) & bb));
    got_c0 = c0;
    h0 = c0;
    h1 = c1;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check_val("hold_valid", 32'({out_valid, in_ready, busy}), 32'b101);
      check_val("hold_c", 32'({c1, c0}), 32'({h1, h0}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("post_hs_c", 32'({c1, c0}), 32'd0);
    check_val("post_hs_flags", 32'({out_valid, busy, in_ready}), 32'b001);
  endtask

  logic [W-1:0] c0_r1, c0_r2, c0_tmp;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_flags", 32'({in_ready, rnd_req, out_valid, busy}), 32'd0);
    check_val("rst_c", 32'({c1, c0}), 32'd0);
    check_val("rst_state", 32'(state_o), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("ready_after_rst", 32'(in_ready), 32'd1);

    // fixed operands, z all ones
    run_op(8'h3C, 8'hCC, 8'h55, 8'hFF, 8'hFF, -1, 0, c0_r1);
    // same operands, alternating z
    run_op(8'h3C, 8'hCC, 8'h55, 8'hFF, 8'hAA, -1, 0, c0_r2);
    check_val("z_diff", 32'(c0_r1 ^ c0_r2), 32'(8'hFF ^ 8'hAA));
    // stall at bit 3 with ack noise outside FETCH
    noise_en = 1'b1;
    run_op(8'h3C, 8'hCC, 8'h55, 8'hFF, 8'hFF, 3, 0, c0_tmp);
    // consumer back-pressure for 10 cycles
    run_op(8'h3C, 8'hCC, 8'h55, 8'hFF, 8'h5A, -1, 10, c0_tmp);

    // asynchronous reset while working on bit 4
    z_vec = 8'hFF; bit_cnt = 0; stall_bit = -1;
    a0 = 8'h3C; a1 = 8'hCC; b0 = 8'h55; b1 = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_val("mid_state", 32'(state_o), 32'(FETCH));
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_flags", 32'({in_ready, rnd_req, out_valid, busy}), 32'd0);
    check_val("mid_rst_c", 32'({c1, c0}), 32'd0);
    check_val("mid_rst_state", 32'(state_o), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(8'h3C, 8'hCC, 8'h55, 8'hFF, 8'h33, -1, 0, c0_tmp);

    // random operands, randomness, stalls and back-pressure
    for (int i = 0; i < N_RAND; i++) begin
      run_op(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1,
             int'($urandom_range(0, 3)), c0_tmp);
    end

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
